scmp_bus_responder: RTL and testbench
=====================================

# scmp_bus_responder

Bus-side responder for the SC/MP-style core: it sits on the external CPU bus driven by the microcode sequencer (ADS_n/RD_n/WR_n strobes plus R/I/D/H status flags) and turns each bus cycle into a single request/acknowledge transaction on a simple memory/peripheral port. It captures the full 16-bit address and cycle flags at the address strobe, stretches the CPU with `bus_hold` until memory acknowledges, and drives read data back onto the bus.

## Interface
Parameters:
- `RD_WAIT`, 1, minimum cycles `bus_hold` stays asserted on a read after the request, even if `mem_ack` is early (0..15).
- `WR_WAIT`, 0, same for writes (0..15).

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk`  in  1  system clock; all bus inputs sampled on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `bus_ADS_n`  in  1  address strobe, active low
- `bus_RD_n`  in  1  read strobe, active low
- `bus_WR_n`  in  1  write strobe, active low
- `bus_A`  in  12  address bits 11:0
- `bus_D_i`  in  8  CPU data; at ADS: [3:0]=A15:12, [4]=R, [5]=I, [6]=D, [7]=H
- `bus_D_o`  out  8  read data to CPU
- `bus_D_oe`  out  1  `bus_D_o` valid/enable
- `bus_hold`  out  1  CPU must stretch current cycle while 1
- `mem_addr`  out  16  latched address
- `mem_rd`  out  1  one-cycle read request
- `mem_wr`  out  1  one-cycle write request
- `mem_wdata`  out  8  write data
- `mem_rdata`  in  8  read data, valid with `mem_ack`
- `mem_ack`  in  1  one-cycle completion from memory
- `cyc_flags`  out  4  latched {H,D,I,R}
- `halt_pulse`  out  1  one-cycle pulse when a cycle with H=1 completes
- `proto_err`  out  1  one-cycle pulse on bus protocol violation

## Operation
- States: IDLE, ADDR, RD_REQ, RD_WAIT, RD_DRIVE, WR_REQ, WR_WAIT.
- IDLE: ADS_n=0 latches `mem_addr={bus_D_i[3:0],bus_A}` and `cyc_flags=bus_D_i[7:4]` -> ADDR.
- ADDR: RD_n=0 -> RD_REQ; WR_n=0 -> WR_REQ (captures `mem_wdata=bus_D_i`); both 0 -> `proto_err`, IDLE; ADS_n=0 again -> relatch, stay ADDR.
- RD_REQ: `mem_rd`=1 one cycle, `bus_hold`=1, wait counter loaded with RD_WAIT -> RD_WAIT.
- RD_WAIT: `bus_hold`=1 until ack seen (sticky) AND counter==0; `mem_rdata` registered on `mem_ack` -> RD_DRIVE.
- RD_DRIVE: `bus_hold`=0, `bus_D_oe`=1, `bus_D_o`=registered data; held until RD_n=1 -> IDLE (`halt_pulse` if H).
- WR_REQ/WR_WAIT: as read with `mem_wr`, WR_WAIT; on completion `bus_hold`=0 and return to IDLE when WR_n=1 (`halt_pulse` if H).
- `mem_ack` in the same cycle as the request counts. `mem_ack` in IDLE/ADDR ignored.
- ADS_n=0 in any non-IDLE state except ADDR: `proto_err`, abandon cycle (drop oe/hold), relatch, -> ADDR. A pending ack is discarded.
- Strobe released (RD_n/WR_n=1) while `bus_hold`=1: `proto_err`, -> IDLE; late `mem_ack` ignored.

## Timing
- Reset: all outputs 0, `mem_addr`/`cyc_flags`/`mem_wdata`/`bus_D_o`=0, state IDLE, wait counter 0; reset mid-cycle drops `bus_hold`/`bus_D_oe` immediately (async).
- ADS sampled edge N -> `mem_addr` valid N+1. RD_n low sampled at M -> `mem_rd` at M+1, `bus_hold`=1 from M+1.
- Read with ack at request cycle, RD_WAIT=k: `bus_D_oe` asserts k+1 cycles after `mem_rd` (k=0: next cycle).
- Otherwise release = max(ack cycle, request+k) + 1.
- `bus_D_oe` deasserts the cycle after RD_n sampled high. All outputs registered; no combinational input->output path.

## Test plan
- ADS with D=0xA3, A=0x456; RD; mem_ack same cycle as `mem_rd`, rdata=0x5C, RD_WAIT=1 -> `mem_addr`=0x3456, `cyc_flags`=0xA, hold 2 cycles, `bus_D_o`=0x5C while RD_n low.
- Write D=0x77 to 0x0100, WR_WAIT=0, ack 3 cycles late -> `mem_wr` one cycle, `mem_wdata`=0x77, hold exactly 4 cycles.
- RD_n and WR_n both low in ADDR -> `proto_err` one pulse, no `mem_rd`/`mem_wr`, state IDLE.
- Read with flags H=1 -> `halt_pulse` once when RD_n released; H=0 read -> no pulse.
- ADS during RD_WAIT, then late ack -> `proto_err`, hold drops, new address latched, late ack produces no data.
- Assert rst_n=0 during RD_DRIVE -> `bus_D_oe`, `bus_hold` 0 asynchronously; after release IDLE, next read works normally.

Source files
------------

// File: rtl/scmp_bus_responder.sv
// SC/MP-style bus responder: turns each ADS/RD/WR bus cycle into one mem_rd/mem_wr
// request, stretches the CPU with bus_hold until the memory acknowledges.
module scmp_bus_responder #(
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_ADS_n,
  input  logic        bus_RD_n,
  input  logic        bus_WR_n,
  input  logic [11:0] bus_A,
  input  logic [7:0]  bus_D_i,
  output logic [7:0]  bus_D_o,
  output logic        bus_D_oe,
  output logic        bus_hold,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [3:0]  cyc_flags,
  output logic        halt_pulse,
  output logic        proto_err
);

  localparam logic [3:0] RD_W = 4'(RD_WAIT);
  localparam logic [3:0] WR_W = 4'(WR_WAIT);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RD_REQ, S_RD_WAIT, S_RD_DRIVE, S_WR_REQ, S_WR_WAIT
  } state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       ack_seen;
  logic       ack_any;
  logic       cnt_zero;
  logic       in_cycle;

  // The ack in the request cycle itself counts, so OR the live ack with the sticky one.
  assign ack_any  = ack_seen | mem_ack;
  assign cnt_zero = (wait_cnt == 4'd0);
  assign in_cycle = (state != S_IDLE) && (state != S_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      ack_seen   <= 1'b0;
      bus_D_o    <= '0;
      bus_D_oe   <= 1'b0;
      bus_hold   <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
      cyc_flags  <= '0;
      halt_pulse <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      halt_pulse <= 1'b0;
      proto_err  <= 1'b0;
      if (in_cycle && !bus_ADS_n) begin
        // New address strobe mid-cycle: abandon the current one and start over.
        proto_err <= 1'b1;
        bus_hold  <= 1'b0;
        bus_D_oe  <= 1'b0;
        ack_seen  <= 1'b0;
        mem_addr  <= {bus_D_i[3:0], bus_A};
        cyc_flags <= bus_D_i[7:4];
        state     <= S_ADDR;
      end else begin
        case (state)
          S_IDLE: begin
            if (!bus_ADS_n) begin
              mem_addr  <= {bus_D_i[3:0], bus_A};
              cyc_flags <= bus_D_i[7:4];
              state     <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (!bus_RD_n && !bus_WR_n) begin
              proto_err <= 1'b1;
              state     <= S_IDLE;
            end else if (!bus_ADS_n) begin
              mem_addr  <= {bus_D_i[3:0], bus_A};
              cyc_flags <= bus_D_i[7:4];
            end else if (!bus_RD_n) begin
              mem_rd   <= 1'b1;
              bus_hold <= 1'b1;
              wait_cnt <= RD_W;
              ack_seen <= 1'b0;
              state    <= S_RD_REQ;
            end else if (!bus_WR_n) begin
              mem_wr    <= 1'b1;
              mem_wdata <= bus_D_i;
              bus_hold  <= 1'b1;
              wait_cnt  <= WR_W;
              ack_seen  <= 1'b0;
              state     <= S_WR_REQ;
            end
          end
          S_RD_REQ, S_RD_WAIT: begin
            if (bus_RD_n) begin
              proto_err <= 1'b1;
              bus_hold  <= 1'b0;
              ack_seen  <= 1'b0;
              state     <= S_IDLE;
            end else begin
              if (mem_ack) begin
                ack_seen <= 1'b1;
                bus_D_o  <= mem_rdata;
              end
              if (ack_any && cnt_zero) begin
                bus_hold <= 1'b0;
                bus_D_oe <= 1'b1;
                state    <= S_RD_DRIVE;
              end else begin
                if (!cnt_zero) wait_cnt <= wait_cnt - 4'd1;
                state <= S_RD_WAIT;
              end
            end
          end
          S_RD_DRIVE: begin
            if (bus_RD_n) begin
              bus_D_oe   <= 1'b0;
              halt_pulse <= cyc_flags[3];
              state      <= S_IDLE;
            end
          end
          S_WR_REQ, S_WR_WAIT: begin
            // WR_WAIT with hold already low means done; just wait for the strobe to lift.
            if (bus_hold) begin
              if (bus_WR_n) begin
                proto_err <= 1'b1;
                bus_hold  <= 1'b0;
                ack_seen  <= 1'b0;
                state     <= S_IDLE;
              end else begin
                if (mem_ack) ack_seen <= 1'b1;
                if (ack_any && cnt_zero) bus_hold <= 1'b0;
                else if (!cnt_zero) wait_cnt <= wait_cnt - 4'd1;
                state <= S_WR_WAIT;
              end
            end else if (bus_WR_n) begin
              halt_pulse <= cyc_flags[3];
              state      <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scmp_bus_responder.sv
// Table-driven bench for scmp_bus_responder with a request scoreboard and memory responder.
module tb_scmp_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_ADS_n, bus_RD_n, bus_WR_n;
  logic [11:0] bus_A;
  logic [7:0]  bus_D_i;
  logic [7:0]  bus_D_o;
  logic        bus_D_oe, bus_hold;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'hEE;
  logic        mem_ack = 1'b0;
  logic [3:0]  cyc_flags;
  logic        halt_pulse, proto_err;

  int checks = 0;
  int errors = 0;

  scmp_bus_responder #(.RD_WAIT(1), .WR_WAIT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_ADS_n(bus_ADS_n), .bus_RD_n(bus_RD_n), .bus_WR_n(bus_WR_n),
    .bus_A(bus_A), .bus_D_i(bus_D_i), .bus_D_o(bus_D_o), .bus_D_oe(bus_D_oe),
    .bus_hold(bus_hold), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .cyc_flags(cyc_flags), .halt_pulse(halt_pulse), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [3:0]  flags;
    logic [7:0]  data;
    int          dly;
    int          exp_hold;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [3:0]  flags;
    logic [7:0]  wdata;
  } req_t;

  req_t sb[$];
  int   resp_dly = 0;
  logic [7:0] resp_data = 8'h00;
  int   resp_cnt = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Memory side: check each request against the scoreboard, then ack after resp_dly cycles.
  always @(negedge clk) begin
    req_t e;
    mem_ack   = 1'b0;
    mem_rdata = 8'hEE;
    if (mem_rd || mem_wr) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req rd=%0b wr=%0b addr=%0h", mem_rd, mem_wr, mem_addr);
      end else begin
        e = sb.pop_front();
        chk("req_kind", {mem_rd, mem_wr}, {~e.wr, e.wr});
        chk("req_addr", mem_addr, e.addr);
        chk("req_flags", cyc_flags, e.flags);
        if (e.wr) chk("req_wdata", mem_wdata, e.wdata);
      end
      resp_cnt = resp_dly;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
    end
    if (resp_cnt == 0) begin
      mem_ack   = 1'b1;
      mem_rdata = resp_data;
      resp_cnt  = -1;
    end
  end

  task automatic addr_phase(input logic [15:0] a, input logic [3:0] f);
    bus_A     = a[11:0];
    bus_D_i   = {f, a[15:12]};
    bus_ADS_n = 1'b0;
    @(negedge clk);
    bus_ADS_n = 1'b1;
  endtask

  task automatic push_req(input logic wr, input logic [15:0] a, input logic [3:0] f, input logic [7:0] d);
    req_t r;
    r.wr = wr; r.addr = a; r.flags = f; r.wdata = d;
    sb.push_back(r);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    resp_dly  = v.dly;
    resp_data = v.data;
    addr_phase(v.addr, v.flags);
    chk("mem_addr", mem_addr, v.addr);
    chk("cyc_flags", cyc_flags, v.flags);
    push_req(v.wr, v.addr, v.flags, v.data);
    if (v.wr) begin
      bus_WR_n = 1'b0;
      bus_D_i  = v.data;
    end else begin
      bus_RD_n = 1'b0;
    end
    @(negedge clk);
    n = 0;
    while (bus_hold && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("hold_cycles", n, v.exp_hold);
    if (!v.wr) begin
      chk("rd_oe", bus_D_oe, 1'b1);
      chk("rd_data", bus_D_o, v.data);
      @(negedge clk);
      chk("rd_oe_held", bus_D_oe, 1'b1);
      chk("rd_data_held", bus_D_o, v.data);
      bus_RD_n = 1'b1;
    end else begin
      bus_WR_n = 1'b1;
    end
    @(negedge clk);
    chk("halt_pulse", halt_pulse, v.flags[3]);
    chk("oe_off", bus_D_oe, 1'b0);
    @(negedge clk);
    chk("halt_once", halt_pulse, 1'b0);
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    int oe_seen;
    vecs[0] = '{1'b0, 16'h3456, 4'hA, 8'h5C, 0, 2};
    vecs[1] = '{1'b1, 16'h0100, 4'h0, 8'h77, 3, 4};
    vecs[2] = '{1'b0, 16'h0ABC, 4'h0, 8'h3C, 0, 2};
    vecs[3] = '{1'b0, 16'hF001, 4'h8, 8'hFF, 3, 4};
    vecs[4] = '{1'b1, 16'h8FFF, 4'h8, 8'h00, 0, 1};
    vecs[5] = '{1'b0, 16'h1234, 4'h1, 8'hA5, 1, 2};
    vecs[6] = '{1'b1, 16'hFFFF, 4'hF, 8'h5A, 1, 2};

    rst_n = 1'b0; bus_ADS_n = 1'b1; bus_RD_n = 1'b1; bus_WR_n = 1'b1;
    bus_A = '0; bus_D_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {bus_D_oe, bus_hold, mem_rd, mem_wr, halt_pulse, proto_err}, 6'b0);
    chk("rst_addr", mem_addr, 16'h0);
    chk("rst_regs", {cyc_flags, mem_wdata, bus_D_o}, 20'h0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // RD_n and WR_n both low in ADDR
    addr_phase(16'h2222, 4'h0);
    bus_RD_n = 1'b0; bus_WR_n = 1'b0;
    @(negedge clk);
    chk("both_err", proto_err, 1'b1);
    chk("both_noreq", {mem_rd, mem_wr, bus_hold}, 3'b0);
    bus_RD_n = 1'b1; bus_WR_n = 1'b1;
    @(negedge clk);
    chk("both_err_pulse", proto_err, 1'b0);
    bus_RD_n = 1'b0;
    @(negedge clk);
    chk("both_idle_norq", mem_rd, 1'b0);
    bus_RD_n = 1'b1;
    repeat (2) @(negedge clk);

    // ADS while waiting for a late ack
    resp_dly = 4; resp_data = 8'h99;
    addr_phase(16'h1111, 4'h0);
    push_req(1'b0, 16'h1111, 4'h0, 8'h00);
    bus_RD_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_hold_pre", bus_hold, 1'b1);
    bus_A = 12'hBCD; bus_D_i = 8'h04; bus_ADS_n = 1'b0;
    @(negedge clk);
    chk("abort_err", proto_err, 1'b1);
    chk("abort_hold", bus_hold, 1'b0);
    chk("abort_addr", mem_addr, 16'h4BCD);
    bus_ADS_n = 1'b1; bus_RD_n = 1'b1;
    oe_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_D_oe || bus_hold) oe_seen++;
    end
    chk("abort_late_ack", oe_seen, 0);

    // RD_n released while hold is asserted
    resp_dly = 4; resp_data = 8'h66;
    addr_phase(16'h0777, 4'h0);
    push_req(1'b0, 16'h0777, 4'h0, 8'h00);
    bus_RD_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus_RD_n = 1'b1;
    @(negedge clk);
    chk("release_err", proto_err, 1'b1);
    chk("release_hold", bus_hold, 1'b0);
    oe_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_D_oe || bus_hold || proto_err) oe_seen++;
    end
    chk("release_late_ack", oe_seen, 0);

    // Async reset while driving read data
    resp_dly = 0; resp_data = 8'h42;
    addr_phase(16'h0042, 4'h0);
    push_req(1'b0, 16'h0042, 4'h0, 8'h00);
    bus_RD_n = 1'b0;
    @(negedge clk);
    n = 0;
    while (bus_hold && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("rst_pre_oe", bus_D_oe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_oe_hold", {bus_D_oe, bus_hold}, 2'b00);
    chk("rst_async_addr", mem_addr, 16'h0);
    @(negedge clk);
    bus_RD_n = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(vecs[0]);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
